// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus (CDB) producer and its consumers.
//   ROB_TAG / ZERO_REG : ROB tag type; tag 0 means "no tag".
//   FU_RESULT          : one queued functional-unit result.
//   CDB_PACKET         : broadcast packet seen by RS, ROB and map table.
//   NUM_FU             : one result port per reservation station.
package cdb_arbiter_pkg;

   localparam int NUM_RS     = 6;
   localparam int NUM_FU     = NUM_RS;
   localparam int XLEN       = 32;
   localparam int ROB_TAG_W  = 5;
   localparam int FU_ID_W    = 3;
   localparam int FIFO_DEPTH = 2;

   typedef logic [ROB_TAG_W-1:0] ROB_TAG;

   localparam ROB_TAG ZERO_REG = '0;

   typedef struct packed {
      ROB_TAG            rob_tag;
      logic [XLEN-1:0]   value;
   } FU_RESULT;

   typedef struct packed {
      logic                valid;
      ROB_TAG              rob_tag;
      logic [XLEN-1:0]     v;
      logic [FU_ID_W-1:0]  fu_id;
   } CDB_PACKET;

endpackage

// File: rtl/cdb_fu_fifo.sv
// Two-entry result FIFO, one per functional unit.
//   clock, reset (async, active low), flush (sync clear of all entries)
//   push/push_data : enqueue, ignored when full
//   pop            : dequeue head, ignored when empty
//   head_data      : current head entry (valid when count != 0)
//   count          : registered occupancy 0..2
module cdb_fu_fifo
   import cdb_arbiter_pkg::*;
#(
   parameter int DATA_W = ROB_TAG_W + XLEN
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head_data,
   output logic [1:0]        count
);

   logic [1:0][DATA_W-1:0] mem;
   logic                   rd_ptr;
   logic                   wr_ptr;
   logic                   push_ok;
   logic                   pop_ok;

   assign push_ok   = push && (count < 2'(FIFO_DEPTH));
   assign pop_ok    = pop && (count != 2'd0);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mem    <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         // Flush wins over any push/pop in the same cycle.
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_ok)
            rd_ptr <= ~rd_ptr;
         // Push+pop together leaves occupancy unchanged.
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB producer: queues FU results per port and broadcasts one per cycle,
// round-robin, on a registered bus.
//   clock, reset (async, active low), squash (sync flush)
//   fu_valid/fu_rob_tag/fu_value : per-FU result ports (port i = fu_id i+1)
//   fu_ready                     : per-FU queue has room (registered count)
//   cdb_valid/cdb_rob_tag/cdb_v/cdb_fu_id : broadcast, all zero when idle
//   busy                         : some queue holds an entry
module cdb_arbiter #(
   parameter int NUM_FU    = cdb_arbiter_pkg::NUM_FU,
   parameter int XLEN      = cdb_arbiter_pkg::XLEN,
   parameter int ROB_TAG_W = cdb_arbiter_pkg::ROB_TAG_W,
   parameter int FU_ID_W   = cdb_arbiter_pkg::FU_ID_W
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      squash,
   input  logic [NUM_FU-1:0]         fu_valid,
   input  logic [NUM_FU*ROB_TAG_W-1:0] fu_rob_tag,
   input  logic [NUM_FU*XLEN-1:0]    fu_value,
   output logic [NUM_FU-1:0]         fu_ready,
   output logic                      cdb_valid,
   output logic [ROB_TAG_W-1:0]      cdb_rob_tag,
   output logic [XLEN-1:0]           cdb_v,
   output logic [FU_ID_W-1:0]        cdb_fu_id,
   output logic                      busy
);

   import cdb_arbiter_pkg::*;

   localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
   localparam int ENT_W = ROB_TAG_W + XLEN;

   logic [NUM_FU-1:0][ROB_TAG_W-1:0] tag_in;
   logic [NUM_FU-1:0][XLEN-1:0]      value_in;
   logic [NUM_FU-1:0][ENT_W-1:0]     head;
   logic [NUM_FU-1:0][1:0]           count;
   logic [NUM_FU-1:0]                push;
   logic [NUM_FU-1:0]                pop;
   logic [NUM_FU-1:0]                nonempty;

   // Holds fu_ready low until the first edge after reset release.
   logic                             ready_en;
   logic [PTR_W-1:0]                 rr_ptr;
   logic [PTR_W-1:0]                 rr_next;
   logic                             grant_vld;
   logic [PTR_W-1:0]                 grant;
   logic [PTR_W:0]                   scan_sum;
   logic [PTR_W-1:0]                 scan_idx;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_FU; gi++) begin : g_fu
         assign tag_in[gi]   = fu_rob_tag[gi*ROB_TAG_W +: ROB_TAG_W];
         assign value_in[gi] = fu_value[gi*XLEN +: XLEN];
         assign nonempty[gi] = (count[gi] != 2'd0);
         assign fu_ready[gi] = ready_en && (count[gi] < 2'(FIFO_DEPTH));
         // Reserved tag is accepted by the handshake but never stored.
         assign push[gi]     = fu_valid[gi] && fu_ready[gi] &&
                               (tag_in[gi] != ROB_TAG_W'(ZERO_REG));
         assign pop[gi]      = grant_vld && (grant == PTR_W'(gi));

         cdb_fu_fifo #(.DATA_W(ENT_W)) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .flush     (squash),
            .push      (push[gi]),
            .push_data ({tag_in[gi], value_in[gi]}),
            .pop       (pop[gi]),
            .head_data (head[gi]),
            .count     (count[gi])
         );
      end
   endgenerate

   assign busy = |nonempty;

   // Round-robin search starting at rr_ptr; first non-empty head wins.
   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      scan_sum  = '0;
      scan_idx  = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
         if (scan_sum >= (PTR_W+1)'(NUM_FU))
            scan_sum = scan_sum - (PTR_W+1)'(NUM_FU);
         scan_idx = scan_sum[PTR_W-1:0];
         if (!grant_vld && nonempty[scan_idx]) begin
            grant_vld = 1'b1;
            grant     = scan_idx;
         end
      end
   end

   assign rr_next = (grant == PTR_W'(NUM_FU-1)) ? '0 : grant + PTR_W'(1);

   // Registered broadcast; idle cycles drive zero tag since consumers
   // match tags without looking at cdb_valid.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ready_en    <= 1'b0;
         rr_ptr      <= '0;
         cdb_valid   <= 1'b0;
         cdb_rob_tag <= '0;
         cdb_v       <= '0;
         cdb_fu_id   <= '0;
      end else begin
         ready_en <= 1'b1;
         if (squash) begin
            rr_ptr      <= '0;
            cdb_valid   <= 1'b0;
            cdb_rob_tag <= '0;
            cdb_v       <= '0;
            cdb_fu_id   <= '0;
         end else if (grant_vld) begin
            rr_ptr      <= rr_next;
            cdb_valid   <= 1'b1;
            cdb_rob_tag <= head[grant][ENT_W-1 -: ROB_TAG_W];
            cdb_v       <= head[grant][XLEN-1:0];
            cdb_fu_id   <= FU_ID_W'({1'b0, grant} + (PTR_W+1)'(1));
         end else begin
            cdb_valid   <= 1'b0;
            cdb_rob_tag <= '0;
            cdb_v       <= '0;
            cdb_fu_id   <= '0;
         end
      end
   end

endmodule
